ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 10: number of configuration flip-flops in the target ccff chain, minimum 1.
REQ-002 The block SHALL have parameter WORD_W, default 4: bitstream word width, minimum 1.
REQ-003 Port prog_clk  in  1: the single clock; the chain is also clocked by prog_clk.
REQ-004 Port pReset  in  1: reset, synchronous and active-high.
REQ-005 Port start  in  1: one-cycle request to begin a configuration sequence.
REQ-006 Port verify_en  in  1: selects a readback verify pass; sampled with start.
REQ-007 Port bs_valid  in  1: bitstream word valid.
REQ-008 Port bs_data  in  WORD_W: bitstream word; bit 0 is shifted first.
REQ-009 Port bs_ready  out  1: controller accepts a word this cycle.
REQ-010 Port ccff_head  out  1: serial data into the chain head.
REQ-011 Port ccff_tail  in  1: serial data from the chain tail.
REQ-012 Port chain_shift_en  out  1: chain clock-enable; the chain advances one bit on each prog_clk edge where it is 1.
REQ-013 Port isol_n  out  1: fabric isolation to the IO tiles; 0 = isolated.
REQ-014 Port busy  out  1: sequence in progress.
REQ-015 Port done  out  1: one-cycle completion pulse.
REQ-016 Port error  out  1: sticky verify-mismatch flag.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, SHIFT and FINISH.
REQ-018 In IDLE, start=1 SHALL cause the following, all on the next cycle:
- move to FETCH;
- latch verify_en into pass_verify;
- clear pass to 0, total_cnt to 0 and error to 0;
- force isol_n to 0.
REQ-019 In any state other than IDLE, start SHALL be ignored.
REQ-020 bs_ready SHALL be 1 only in FETCH; a word is accepted on a cycle where bs_valid and bs_ready are both 1.
REQ-021 bs_valid outside FETCH SHALL be ignored.
REQ-022 On acceptance, the block SHALL move to SHIFT with shift_reg = bs_data and bit_cnt = 0.
REQ-023 In SHIFT, the block SHALL drive ccff_head = shift_reg[0] and chain_shift_en = 1 every cycle.
- Each cycle: shift shift_reg right by 1, increment bit_cnt and total_cnt.
REQ-024 When total_cnt reaches CHAIN_LEN-1 in SHIFT, that cycle SHALL be the last shift of the pass; bits remaining in the current word are discarded.
REQ-025 Otherwise, when bit_cnt reaches WORD_W-1, the block SHALL return to FETCH after that shift.
REQ-026 At the end of a pass:
- pass 0 with pass_verify=1: set pass=1, clear total_cnt, go to FETCH;
- otherwise: go to FINISH.
REQ-027 In pass 1 (verify), the requester SHALL resend the identical stream.
- Each SHIFT cycle, the block compares ccff_tail with shift_reg[0] before the clock edge.
- Any mismatch sets error=1.
REQ-028 chain_shift_en SHALL be 0 in IDLE, FETCH and FINISH; ccff_head SHALL be 0 when chain_shift_en is 0.
REQ-029 FINISH SHALL last one cycle and then go to IDLE. In that cycle:
- done = 1;
- isol_n is set to 1 from the next cycle if error=0, and stays 0 if error=1.
REQ-030 busy SHALL be 1 in FETCH, SHIFT and FINISH, and 0 in IDLE.
REQ-031 Total shifts per pass SHALL be exactly CHAIN_LEN.
- Words per pass = ceil(CHAIN_LEN/WORD_W).
- Pass latency = CHAIN_LEN SHIFT cycles plus one FETCH cycle per word when bs_valid is held at 1.
REQ-032 Counter widths SHALL be clog2(CHAIN_LEN+1) for total_cnt and clog2(WORD_W+1) for bit_cnt, with no wrap within a pass.
REQ-033 A stalled requester (bs_valid=0 in FETCH) SHALL hold all state indefinitely with chain_shift_en=0.

Reset
REQ-034 pReset=1 at a prog_clk edge SHALL, from any state including mid-SHIFT, set:
- state = IDLE;
- bs_ready, ccff_head, chain_shift_en, busy and done = 0;
- error = 0;
- isol_n = 0;
- all counters and shift_reg = 0.
REQ-035 After reset, isol_n SHALL remain 0 until the first error-free FINISH.

Verification (CHAIN_LEN=10, WORD_W=4, chain model = 10-bit shift register)
REQ-036 Load without verify:
- stimulus: start with verify_en=0; words 4'hA, 4'h5, 4'h3, bs_valid held 1;
- required: exactly 10 chain_shift_en cycles; head sequence 0,1,0,1,1,0,1,0,1,1;
- required: done pulses once; isol_n = 1 afterwards; error = 0.
REQ-037 Verify pass with a correct chain:
- stimulus: verify_en=1, same three words sent twice;
- required: 20 shifts; error = 0; done = 1; isol_n = 1.
REQ-038 Verify pass with a fault:
- stimulus: as REQ-037 with the chain model bit 3 forced to 0 during pass 1;
- required: error = 1 at FINISH; isol_n stays 0.
REQ-039 Stall:
- stimulus: bs_valid=0 for 5 cycles between words 1 and 2;
- required: chain_shift_en = 0 during the stall; final chain content identical to REQ-036.
REQ-040 Reset mid-operation:
- stimulus: pReset asserted during the 6th shift;
- required: next cycle state is IDLE, busy = 0, isol_n = 0, chain_shift_en = 0;
- required: a new start followed by the REQ-036 stream completes normally.
REQ-041 start while busy:
- stimulus: start pulsed during SHIFT;
- required: no effect; total shifts remain 10.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: bitstream word handshake between requester and loader
interface ccff_chain_loader_if #(
  parameter int WORD_W = 4
);
  logic              bs_valid;
  logic [WORD_W-1:0] bs_data;
  logic              bs_ready;
  modport master (output bs_valid, bs_data, input bs_ready);
  modport slave  (input bs_valid, bs_data, output bs_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words into a ccff chain with optional readback verify
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 4
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               start,
  input  logic               verify_en,
  ccff_chain_loader_if.slave bs,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               chain_shift_en,
  output logic               isol_n,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WORD_W - 1);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;
  state_t            state_q, state_d;
  logic              pass_verify_q, pass_verify_d;
  logic              pass_q, pass_d;
  logic [TW-1:0]     total_cnt_q, total_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
  logic              error_q, error_d;
  logic              isol_n_q, isol_n_d;
  assign bs.bs_ready    = state_q == FETCH;
  assign chain_shift_en = state_q == SHIFT;
  assign ccff_head      = chain_shift_en & shift_reg_q[0];
  assign busy           = state_q != IDLE;
  assign done           = state_q == FINISH;
  assign error          = error_q;
  assign isol_n         = isol_n_q;
  // state and datapath registers
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q       <= IDLE;
      pass_verify_q <= 1'b0;
      pass_q        <= 1'b0;
      total_cnt_q   <= '0;
      bit_cnt_q     <= '0;
      shift_reg_q   <= '0;
      error_q       <= 1'b0;
      isol_n_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pass_verify_q <= pass_verify_d;
      pass_q        <= pass_d;
      total_cnt_q   <= total_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_reg_q   <= shift_reg_d;
      error_q       <= error_d;
      isol_n_q      <= isol_n_d;
    end
  end
  // sequencing: fetch a word, shift it out LSB first, end the pass after CHAIN_LEN bits
  always_comb begin
    state_d       = state_q;
    pass_verify_d = pass_verify_q;
    pass_d        = pass_q;
    total_cnt_d   = total_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_reg_d   = shift_reg_q;
    error_d       = error_q;
    isol_n_d      = isol_n_q;
    case (state_q)
      IDLE: if (start) begin
        state_d       = FETCH;
        pass_verify_d = verify_en;
        pass_d        = 1'b0;
        total_cnt_d   = '0;
        error_d       = 1'b0;
        isol_n_d      = 1'b0;
      end
      FETCH: if (bs.bs_valid) begin
        state_d     = SHIFT;
        shift_reg_d = bs.bs_data;
        bit_cnt_d   = '0;
      end
      SHIFT: begin
        shift_reg_d = shift_reg_q >> 1;
        bit_cnt_d   = bit_cnt_q + BW'(1);
        total_cnt_d = total_cnt_q + TW'(1);
        error_d     = error_q | (pass_q & (ccff_tail != shift_reg_q[0]));
        if (total_cnt_q == T_LAST) begin
          state_d     = (!pass_q && pass_verify_q) ? FETCH : FINISH;
          pass_d      = pass_q | pass_verify_q;
          total_cnt_d = (!pass_q && pass_verify_q) ? '0 : total_cnt_d;
        end else if (bit_cnt_q == B_LAST) begin
          state_d = FETCH;
        end
      end
      FINISH: begin
        state_d  = IDLE;
        isol_n_d = !error_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized scoreboard bench with a behavioural chain model
module tb_ccff_chain_loader;
  localparam int CL = 10;
  localparam int W  = 4;
  localparam int NW = (CL + W - 1) / W;
  localparam int SB = NW * W;
  localparam int FB = 3;
  logic clk = 0, pReset = 1, start = 0, verify_en = 0;
  logic ccff_head, ccff_tail, chain_shift_en, isol_n, busy, done, error;
  ccff_chain_loader_if #(.WORD_W(W)) bs_if();
  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .prog_clk(clk), .pReset(pReset), .start(start), .verify_en(verify_en), .bs(bs_if),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .chain_shift_en(chain_shift_en),
    .isol_n(isol_n), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // chain model: head enters index 0, tail leaves index CL-1; optional stuck-at-0 on bit FB
  logic [CL-1:0] chain = '0, chain_eff;
  logic en_n = 0, head_n = 0, fault_arm = 0;
  int cshift = 0, cbase = 0;
  assign chain_eff = (fault_arm && (cshift - cbase) >= CL) ? (chain & ~(CL'(1) << FB)) : chain;
  assign ccff_tail = chain_eff[CL-1];
  always @(negedge clk) begin
    en_n   = chain_shift_en;
    head_n = ccff_head;
  end
  always @(posedge clk) if (en_n) begin
    chain  <= {chain_eff[CL-2:0], head_n};
    cshift <= cshift + 1;
  end
  // requester: presents queued words, holds bs_valid low for a word's stall cycles while ready
  logic [W-1:0] word_q[$];
  int stall_q[$];
  logic acc_pend = 0;
  always @(negedge clk) begin
    if (acc_pend) begin
      void'(word_q.pop_front());
      void'(stall_q.pop_front());
    end
    acc_pend = 0;
    bs_if.bs_valid = 0;
    bs_if.bs_data = W'($urandom);
    if (word_q.size() > 0) begin
      if (stall_q[0] > 0 && bs_if.bs_ready) stall_q[0] = stall_q[0] - 1;
      else if (stall_q[0] == 0) begin
        bs_if.bs_valid = 1;
        bs_if.bs_data = word_q[0];
        acc_pend = bs_if.bs_ready && !pReset;
      end
    end
  end
  // monitor: pops expected head bits per shift and expected error per done pulse
  logic head_q[$];
  logic done_q[$];
  int shifts = 0, dones = 0;
  logic isol_pend = 0, isol_exp = 0;
  always @(negedge clk) if (!pReset) begin
    check("head_gated", ccff_head & ~chain_shift_en, 0);
    check("ready_vs_shift", bs_if.bs_ready & chain_shift_en, 0);
    check("busy_cover", (bs_if.bs_ready | chain_shift_en | done) & ~busy, 0);
    if (isol_pend) begin
      check("isol_after_done", isol_n, isol_exp);
      isol_pend = 0;
    end
    if (chain_shift_en) begin
      shifts++;
      if (head_q.size() == 0) check("head_extra_shift", 1, 0);
      else check("head_bit", ccff_head, head_q.pop_front());
    end
    if (done) begin
      dones++;
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        isol_exp = !done_q.pop_front();
        check("done_error", error, !isol_exp);
        isol_pend = 1;
      end
    end
  end
  task automatic load_stream(input logic [SB-1:0] s, input int passes, input int stall1);
    for (int p = 0; p < passes; p++) begin
      for (int b = 0; b < CL; b++) head_q.push_back(s[b]);
      for (int k = 0; k < NW; k++) begin
        word_q.push_back(s[k*W +: W]);
        stall_q.push_back((p == 0 && k == 1) ? stall1 : 0);
      end
    end
  endtask
  task automatic run(input logic v, input logic fault, input logic [SB-1:0] s,
                     input int stall1, input logic mid_start);
    int s0, d0;
    logic exp_err;
    exp_err = 0;
    if (v && fault) for (int j = CL - 1 - FB; j < CL; j++) exp_err |= s[j];
    @(posedge clk); #1;
    s0 = shifts;
    d0 = dones;
    cbase = cshift;
    fault_arm = fault;
    load_stream(s, v ? 2 : 1, stall1);
    done_q.push_back(exp_err);
    start = 1;
    verify_en = v;
    @(posedge clk); #1;
    start = 0;
    verify_en = 1'($urandom);
    if (mid_start) begin
      for (int i = 0; i < 50 && !chain_shift_en; i++) begin @(posedge clk); #1; end
      start = 1;
      verify_en = 1'($urandom);
      @(posedge clk); #1;
      start = 0;
    end
    for (int i = 0; i < 300 && dones == d0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("done_count", dones - d0, 1);
    check("shift_count", shifts - s0, v ? 2 * CL : CL);
    check("head_q_empty", head_q.size(), 0);
    check("error_final", error, exp_err);
    check("isol_final", isol_n, !exp_err);
    check("busy_final", busy, 0);
    for (int k = 0; k < CL; k++) if (!fault) check("chain_bit", chain[k], s[CL-1-k]);
    fault_arm = 0;
    head_q.delete();
    done_q.delete();
  endtask
  task automatic reset_mid(input logic [SB-1:0] s);
    @(posedge clk); #1;
    load_stream(s, 1, 0);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 60 && !(chain_shift_en && shifts == 5); i++) begin
      @(posedge clk); #2;
      if (i == 0) shifts = 0;
    end
    check("reset_at_shift6", chain_shift_en, 1);
    pReset = 1;
    @(posedge clk); #1;
    pReset = 0;
    word_q.delete();
    stall_q.delete();
    head_q.delete();
    done_q.delete();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_isol", isol_n, 0);
    check("rst_shift_en", chain_shift_en, 0);
    check("rst_ready", bs_if.bs_ready, 0);
    check("rst_error", error, 0);
  endtask
  localparam logic [SB-1:0] REF = 12'h35A;
  initial begin
    bs_if.bs_valid = 0;
    bs_if.bs_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_ready", bs_if.bs_ready, 0);
    check("init_shift_en", chain_shift_en, 0);
    check("init_head", ccff_head, 0);
    check("init_error", error, 0);
    check("init_isol", isol_n, 0);
    @(posedge clk); #1;
    pReset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_isol", isol_n, 0);
    run(0, 0, REF, 0, 0);
    run(1, 0, REF, 0, 0);
    run(1, 1, REF, 0, 0);
    run(0, 0, REF, 5, 0);
    run(0, 0, REF, 0, 1);
    reset_mid(REF);
    run(0, 0, REF, 0, 0);
    for (int t = 0; t < 25; t++) begin
      logic v;
      v = 1'($urandom);
      run(v, v & 1'($urandom), SB'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
